mcp3008_scheduler: RTL and testbench

MCP3008_SCHEDULER -- requirements
Module: mcp3008_scheduler

---
 rtl/mcp3008_scheduler.sv | 199 +++++++++++++++++++
 tb/tb_mcp3008_scheduler.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcp3008_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mcp3008_scheduler: round-robin front end sharing one MCP3008 SPI ADC      |
// | between four requesters.                              Revision: 1.0       |
// +--------------------------------------------------------------------------+
module mcp3008_scheduler #(
    parameter int          HALF_DIV = 14,
    parameter logic [11:0] CHAN_MAP = 12'b011_010_001_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [3:0] done,
    output logic [9:0] data,
    output logic [2:0] data_ch,
    output logic       busy,
    output logic       AD_CLK,
    output logic       CS,
    output logic       DIN,
    input  logic       DOUT
);
    localparam int               CNT_W        = $clog2(2 * HALF_DIV);
    localparam logic [CNT_W-1:0] C_HALF_LAST  = CNT_W'(HALF_DIV - 1);
    localparam logic [CNT_W-1:0] C_GAP_LAST   = CNT_W'(2 * HALF_DIV - 1);
    localparam logic [5:0]       C_LAST_HALF  = 6'd33;
    localparam logic [5:0]       C_FIRST_DATA = 6'd15;

    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_XFER = 2'd1;
    localparam logic [1:0] C_GAP  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [1:0]       rr_ptr_q, rr_ptr_d;
    logic [1:0]       win_q, win_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       half_q, half_d;
    logic [8:0]       shift_q, shift_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [3:0]       done_q, done_d;
    logic [9:0]       data_q, data_d;
    logic [2:0]       data_ch_q, data_ch_d;
    logic             busy_q, busy_d;
    logic             ad_clk_q, ad_clk_d;
    logic             cs_q, cs_d;
    logic             din_q, din_d;

    logic [1:0] w_winner;
    logic [2:0] w_chan;
    logic [5:0] w_next_half;
    logic [4:0] w_frame_k;
    logic       w_frame_bit;

    // Descending scan so the requester closest to rr_ptr (upward, wrapping) wins.
    always_comb begin
        w_winner = rr_ptr_q;
        for (int i = 3; i >= 0; i--) begin
            if (req[2'(rr_ptr_q + 2'(i))]) begin
                w_winner = 2'(rr_ptr_q + 2'(i));
            end
        end
    end

    always_comb begin
        w_chan      = CHAN_MAP[3*win_q +: 3];
        w_next_half = half_q + 6'd1;
        w_frame_k   = w_next_half[5:1];
        case (w_frame_k)
            5'd0, 5'd1: w_frame_bit = 1'b1;
            5'd2:       w_frame_bit = w_chan[2];
            5'd3:       w_frame_bit = w_chan[1];
            5'd4:       w_frame_bit = w_chan[0];
            default:    w_frame_bit = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        win_d     = win_q;
        cnt_d     = cnt_q;
        half_d    = half_q;
        shift_d   = shift_q;
        gnt_d     = gnt_q;
        done_d    = 4'b0000;
        data_d    = data_q;
        data_ch_d = data_ch_q;
        busy_d    = busy_q;
        ad_clk_d  = ad_clk_q;
        cs_d      = cs_q;
        din_d     = din_q;
        case (state_q)
            C_IDLE: begin
                if (|req) begin
                    state_d  = C_XFER;
                    win_d    = w_winner;
                    rr_ptr_d = w_winner + 2'd1;
                    gnt_d    = 4'b0001 << w_winner;
                    cnt_d    = '0;
                    half_d   = '0;
                    shift_d  = '0;
                    busy_d   = 1'b1;
                    cs_d     = 1'b0;
                    ad_clk_d = 1'b0;
                    din_d    = 1'b1;
                end
            end
            C_XFER: begin
                if (cnt_q == C_HALF_LAST) begin
                    cnt_d = '0;
                    // Sample DOUT on the last clk of each high half from h=15 on.
                    if (half_q[0] && (half_q >= C_FIRST_DATA)) begin
                        shift_d = {shift_q[7:0], DOUT};
                    end
                    if (half_q == C_LAST_HALF) begin
                        state_d   = C_GAP;
                        cs_d      = 1'b1;
                        ad_clk_d  = 1'b0;
                        din_d     = 1'b0;
                        gnt_d     = 4'b0000;
                        done_d    = gnt_q;
                        data_d    = {shift_q, DOUT};
                        data_ch_d = w_chan;
                    end else begin
                        half_d   = w_next_half;
                        ad_clk_d = w_next_half[0];
                        if (!w_next_half[0]) begin
                            din_d = w_frame_bit;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            C_GAP: begin
                if (cnt_q == C_GAP_LAST) begin
                    state_d = C_IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d  = C_IDLE;
                gnt_d    = 4'b0000;
                busy_d   = 1'b0;
                cs_d     = 1'b1;
                ad_clk_d = 1'b0;
                din_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= C_IDLE;
            rr_ptr_q  <= '0;
            win_q     <= '0;
            cnt_q     <= '0;
            half_q    <= '0;
            shift_q   <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            data_q    <= '0;
            data_ch_q <= '0;
            busy_q    <= 1'b0;
            ad_clk_q  <= 1'b0;
            cs_q      <= 1'b1;
            din_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            win_q     <= win_d;
            cnt_q     <= cnt_d;
            half_q    <= half_d;
            shift_q   <= shift_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            data_q    <= data_d;
            data_ch_q <= data_ch_d;
            busy_q    <= busy_d;
            ad_clk_q  <= ad_clk_d;
            cs_q      <= cs_d;
            din_q     <= din_d;
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign data    = data_q;
    assign data_ch = data_ch_q;
    assign busy    = busy_q;
    assign AD_CLK  = ad_clk_q;
    assign CS      = cs_q;
    assign DIN     = din_q;

endmodule
`default_nettype wire

// File: tb/tb_mcp3008_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mcp3008_scheduler: directed scoreboard bench with an MCP3008 slave     |
// | model per instance.                                   Revision: 1.0       |
// +--------------------------------------------------------------------------+
module tb_mcp3008_scheduler;
    localparam int          HALF_DIV = 2;
    localparam logic [11:0] MAP_A    = 12'b011_010_001_000;
    localparam logic [11:0] MAP_B    = 12'b011_010_101_000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req_a, req_b;
    logic [3:0] gnt_a, gnt_b, done_a, done_b;
    logic [9:0] data_a, data_b;
    logic [2:0] ch_a, ch_b;
    logic       busy_a, busy_b;
    logic [1:0] ad_clk_w, cs_w, din_w;
    logic [1:0] dout_r = 2'b00;

    always #5 clk = ~clk;

    mcp3008_scheduler #(.HALF_DIV(HALF_DIV), .CHAN_MAP(MAP_A)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .req(req_a), .gnt(gnt_a), .done(done_a),
        .data(data_a), .data_ch(ch_a), .busy(busy_a),
        .AD_CLK(ad_clk_w[0]), .CS(cs_w[0]), .DIN(din_w[0]), .DOUT(dout_r[0])
    );

    mcp3008_scheduler #(.HALF_DIV(HALF_DIV), .CHAN_MAP(MAP_B)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .req(req_b), .gnt(gnt_b), .done(done_b),
        .data(data_b), .data_ch(ch_b), .busy(busy_b),
        .AD_CLK(ad_clk_w[1]), .CS(cs_w[1]), .DIN(din_w[1]), .DOUT(dout_r[1])
    );

    // Conversion value the slave model returns for a decoded channel.
    function automatic logic [9:0] resp(input logic [2:0] ch);
        return 10'h2A5 + 10'(ch) * 10'h03B;
    endfunction

    // ---------------- MCP3008 slave model and bus checker ----------------
    int          rises [2];
    logic [16:0] frame [2];
    logic [1:0]  prev_ad  = 2'b00;
    logic [1:0]  prev_cs  = 2'b11;
    logic [1:0]  prev_din = 2'b00;
    logic [9:0]  model_v;
    int          proto_errs = 0;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (prev_cs[i] && !cs_w[i]) begin
                if (ad_clk_w[i]) proto_errs++;
                rises[i] = 0;
                frame[i] = '0;
            end
            if (!cs_w[i] && prev_ad[i] && ad_clk_w[i] && (din_w[i] !== prev_din[i])) proto_errs++;
            if (!cs_w[i] && !prev_ad[i] && ad_clk_w[i]) begin
                if (rises[i] < 17) frame[i][rises[i]] = din_w[i];
                rises[i]++;
            end
            if (cs_w[i]) begin
                dout_r[i] = 1'b0;
            end else if (prev_ad[i] && !ad_clk_w[i]) begin
                if (rises[i] >= 7 && rises[i] <= 16) begin
                    model_v   = resp({frame[i][2], frame[i][3], frame[i][4]});
                    dout_r[i] = model_v[16 - rises[i]];
                end else begin
                    dout_r[i] = 1'b0;
                end
            end
            prev_ad[i]  = ad_clk_w[i];
            prev_cs[i]  = cs_w[i];
            prev_din[i] = din_w[i];
        end
        if ($countones(gnt_a) > 1 || $countones(gnt_b) > 1) proto_errs++;
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int         inst;
        logic [3:0] who;
        logic [2:0] ch;
        logic [9:0] dat;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_exp(input int inst, input int who, input logic [11:0] map);
        exp_t e;
        e.inst = inst;
        e.who  = 4'b0001 << who;
        e.ch   = map[3*who +: 3];
        e.dat  = resp(e.ch);
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        req_a = '0;
        req_b = '0;
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    // Waits (bounded) for a done pulse; the current sample must not be a done cycle.
    task automatic wait_txn(input int inst, output int lat, output int g_cnt,
                            output logic [3:0] g_first, output int cs_hi);
        logic [3:0] g, d;
        int         t_g;
        lat = -1; g_cnt = 0; g_first = '0; cs_hi = 0; t_g = 0;
        for (int n = 0; n < 400; n++) begin
            g = (inst == 1) ? gnt_b : gnt_a;
            d = (inst == 1) ? done_b : done_a;
            if (g_first == 4'b0 && g != 4'b0) begin
                g_first = g;
                t_g     = n;
            end
            if (g_first == 4'b0 && cs_w[inst] === 1'b1) cs_hi++;
            if (g_first != 4'b0 && g == g_first) g_cnt++;
            if (d != 4'b0) begin
                lat = n - t_g;
                return;
            end
            step(1);
        end
    endtask

    task automatic check_txn(input int inst, input int lat, input int g_cnt,
                             input logic [3:0] g_first, input int exp_lat, input string tag);
        exp_t e;
        chk({tag, "_sb_nonempty"}, 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() == 0) return;
        e = sb_q.pop_front();
        chk({tag, "_gnt"},     g_first, e.who);
        chk({tag, "_gnt_len"}, g_cnt, exp_lat);
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_done"},    (inst == 1) ? done_b : done_a, e.who);
        chk({tag, "_data"},    (inst == 1) ? data_b : data_a, e.dat);
        chk({tag, "_data_ch"}, (inst == 1) ? ch_b : ch_a, e.ch);
        chk({tag, "_cs_at_done"}, cs_w[inst], 1'b1);
        chk({tag, "_frame"},   frame[inst], {12'b0, e.ch[0], e.ch[1], e.ch[2], 2'b11});
    endtask

    initial begin
        int         lat, g_cnt, cs_hi;
        logic [3:0] g_first;

        rst_n = 1'b0;
        req_a = '0;
        req_b = '0;
        step(1);
        chk("rst_cs",      cs_w[0], 1'b1);
        chk("rst_ad_clk",  ad_clk_w[0], 1'b0);
        chk("rst_din",     din_w[0], 1'b0);
        chk("rst_gnt",     gnt_a, 4'b0000);
        chk("rst_done",    done_a, 4'b0000);
        chk("rst_busy",    busy_a, 1'b0);
        chk("rst_data",    data_a, 10'h000);
        chk("rst_data_ch", ch_a, 3'd0);
        rst_n = 1'b1;
        step(2);

        // Single request on channel 0.
        req_a = 4'b0001;
        push_exp(0, 0, MAP_A);
        step(1);
        chk("t1_gnt",    gnt_a, 4'b0001);
        chk("t1_cs",     cs_w[0], 1'b0);
        chk("t1_ad_clk", ad_clk_w[0], 1'b0);
        chk("t1_din",    din_w[0], 1'b1);
        chk("t1_busy",   busy_a, 1'b1);
        wait_txn(0, lat, g_cnt, g_first, cs_hi);
        check_txn(0, lat, g_cnt, g_first, 34 * HALF_DIV, "single");
        req_a = 4'b0000;
        step(1);
        chk("single_done_once", done_a, 4'b0000);
        step(5);
        chk("single_idle_busy", busy_a, 1'b0);
        chk("single_data_hold", data_a, 10'h2A5);

        // All four requesters; each drops after its own done.
        do_reset();
        req_a = 4'b1111;
        for (int k = 0; k < 4; k++) push_exp(0, k, MAP_A);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step(1);
            wait_txn(0, lat, g_cnt, g_first, cs_hi);
            check_txn(0, lat, g_cnt, g_first, 34 * HALF_DIV, "rr4");
            req_a = req_a & ~done_a;
        end
        step(2 * HALF_DIV + 3);
        chk("rr4_no_extra_gnt", gnt_a, 4'b0000);
        chk("rr4_idle_busy",    busy_a, 1'b0);

        // Requesters 0 and 2 held: alternate with a fixed CS-high gap.
        do_reset();
        req_a = 4'b0101;
        push_exp(0, 0, MAP_A);
        push_exp(0, 2, MAP_A);
        push_exp(0, 0, MAP_A);
        push_exp(0, 2, MAP_A);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step(1);
            wait_txn(0, lat, g_cnt, g_first, cs_hi);
            check_txn(0, lat, g_cnt, g_first, 34 * HALF_DIV, "alt");
            if (k > 0) chk("alt_cs_gap", cs_hi + 1, 2 * HALF_DIV + 1);
        end
        req_a = 4'b0000;

        // Reset in the middle of a frame.
        do_reset();
        req_a = 4'b0001;
        step(1);
        chk("mid_rst_pre_gnt", gnt_a, 4'b0001);
        step(40);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cs",   cs_w[0], 1'b1);
        chk("mid_rst_gnt",  gnt_a, 4'b0000);
        chk("mid_rst_busy", busy_a, 1'b0);
        req_a = 4'b0000;
        step(2);
        chk("mid_rst_no_done", done_a, 4'b0000);
        chk("mid_rst_data",    data_a, 10'h000);
        rst_n = 1'b1;
        step(1);
        req_a = 4'b0100;
        push_exp(0, 2, MAP_A);
        step(1);
        wait_txn(0, lat, g_cnt, g_first, cs_hi);
        check_txn(0, lat, g_cnt, g_first, 34 * HALF_DIV, "post_rst");
        req_a = 4'b0000;

        // Requester 1 drops one clk after grant; channel map sends it to channel 5.
        step(2);
        req_b = 4'b0010;
        push_exp(1, 1, MAP_B);
        step(1);
        chk("drop_gnt", gnt_b, 4'b0010);
        step(1);
        req_b = 4'b0000;
        wait_txn(1, lat, g_cnt, g_first, cs_hi);
        check_txn(1, lat + 1, g_cnt + 1, g_first, 34 * HALF_DIV, "drop");
        chk("drop_busy_gap", busy_b, 1'b1);

        step(2 * HALF_DIV + 2);
        chk("protocol_errors", proto_errs, 0);
        chk("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
